spi_slave_gen: RTL and testbench
================================

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 SHALL provide parameter DW, default 16, word width in bits (legal range 4..32).
REQ-002 SHALL provide parameter SYNC, default 2, number of synchronizer flops on i_sck, i_ss and i_mosi (legal range 2..3).
REQ-003 SHALL provide parameter FILL, default 1'b1, bit shifted out when no TX word is available.
REQ-004 SHALL provide port i_clk, input, 1, system clock; i_clk frequency SHALL be at least 4x SCK frequency times SYNC.
REQ-005 SHALL provide port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL provide port i_sck, input, 1, raw SPI clock, asynchronous to i_clk.
REQ-007 SHALL provide port i_ss, input, 1, raw slave select, active-low.
REQ-008 SHALL provide port i_mosi, input, 1, raw serial data in.
REQ-009 SHALL provide port i_mode, input, 2, {CPOL,CPHA}, sampled only while SS is deasserted.
REQ-010 SHALL provide port i_msb, input, 1, 1 = MSB first, 0 = LSB first, sampled only while SS is deasserted.
REQ-011 SHALL provide port i_tx_data, input, DW, transmit word.
REQ-012 SHALL provide port i_tx_valid, input, 1, transmit word offered.
REQ-013 SHALL provide port o_tx_ready, output, 1, TX holding register empty.
REQ-014 SHALL provide port o_rx_data, output, DW, last received word.
REQ-015 SHALL provide port o_rx_valid, output, 1, o_rx_data unread.
REQ-016 SHALL provide port i_rx_ready, input, 1, consumer accepts o_rx_data.
REQ-017 SHALL provide port o_miso, output, 1, serial data out.
REQ-018 SHALL provide port o_miso_oe, output, 1, MISO output enable, equal to synchronized SS asserted.
REQ-019 SHALL provide port o_busy, output, 1, frame active, equal to synchronized SS asserted.
REQ-020 SHALL provide port o_overrun, output, 1, sticky RX overrun flag.
REQ-021 SHALL provide port o_underrun, output, 1, sticky TX underrun flag.
REQ-022 SHALL provide port i_clr_flags, input, 1, synchronous clear of o_overrun and o_underrun.

Function
REQ-023 SHALL detect SCK edges and SS edges from the synchronized signals as single-cycle pulses in the i_clk domain.
REQ-024 SHALL latch mode and bit order from i_mode and i_msb on the SS falling edge; they SHALL stay constant for the frame.
REQ-025 SHALL define the leading edge as the SCK transition away from CPOL and the trailing edge as the transition back to CPOL.
REQ-026 SHALL sample MOSI on the leading edge when CPHA=0 and on the trailing edge when CPHA=1; the other edge is the shift edge.
REQ-027 SHALL load the TX shifter on the SS falling edge and again on the sample edge that completes each word, so the next bit is presented on MISO before the next shift edge.
REQ-028 SHALL NOT shift MISO on the first shift edge of a frame when CPHA=1.
REQ-029 SHALL drive o_miso from shifter bit DW-1 when MSB first and from bit 0 when LSB first; vacated bits SHALL fill with FILL.
REQ-030 SHALL accept a TX word when i_tx_valid and o_tx_ready are both high, clearing o_tx_ready on the next cycle.
REQ-031 SHALL set o_tx_ready again in the cycle a word moves from the holding register to the shifter.
REQ-032 SHALL load a word of all FILL bits when the holding register is empty at a load point, and SHALL set o_underrun.
REQ-033 SHALL move a word accepted in the same cycle as a load point directly into the shifter, with no underrun.
REQ-034 SHALL count sample edges from 0 to DW-1 with a counter of width clog2(DW), wrapping to 0.
REQ-035 SHALL, on the DW-th sample edge, copy the completed word including the current bit to o_rx_data and set o_rx_valid.
REQ-036 SHALL clear o_rx_valid when i_rx_ready is high, unless a new word completes in the same cycle, in which case o_rx_valid SHALL stay high.
REQ-037 SHALL, when a word completes while o_rx_valid is high and i_rx_ready is low, overwrite o_rx_data and set o_overrun.
REQ-038 SHALL, on SS deassert mid-word, discard the partial RX word, reset the counter, and keep the holding register contents.
REQ-039 SHALL let i_clr_flags take priority over a simultaneous flag set.
REQ-040 SHALL support back-to-back words within one SS frame indefinitely.

Reset
REQ-041 SHALL, on i_rst_n low, immediately clear o_rx_data, o_rx_valid, o_overrun, o_underrun, o_busy and o_miso_oe, and the counter.
REQ-042 SHALL, on reset, set o_tx_ready=1, the shifter to all FILL, and o_miso=FILL.
REQ-043 SHALL, when reset is asserted mid-frame, abort the frame; after release the block SHALL wait for a fresh SS falling edge.

Verification
REQ-044 SHALL cover: mode 0, MSB first, DW=16, TX 0xA55A, MOSI 0x1234 -> MISO bits 0xA55A, o_rx_data=0x1234, one o_rx_valid.
REQ-045 SHALL cover: modes 1, 2 and 3, LSB first, TX 0x00FF, MOSI 0xF00F -> MISO 0x00FF LSB first, o_rx_data=0xF00F in each mode.
REQ-046 SHALL cover: two words in one frame, second TX not supplied -> second word on MISO = 0xFFFF, o_underrun=1.
REQ-047 SHALL cover: two words received, i_rx_ready held low -> o_rx_data = second word, o_overrun=1; i_clr_flags clears it.
REQ-048 SHALL cover: SS deasserted after 7 bits, then a full frame MOSI 0xBEEF -> no o_rx_valid from the partial frame, o_rx_data=0xBEEF.
REQ-049 SHALL cover: i_rst_n pulsed mid-frame -> all outputs at reset values; the next full frame is received correctly.

Source files
------------

// File: rtl/spi_slave_gen.sv
// SPI slave with synchronized SCK/SS/MOSI, all four SPI modes, selectable bit order,
// a one-word TX holding register and a one-word RX output register with overrun/underrun flags.
//
// state    | meaning
// ST_IDLE  | no frame; waiting for a synchronized SS falling edge
// ST_FRAME | SS asserted; sampling MOSI and shifting MISO on SCK edges
module spi_slave_gen #(
    parameter int   DW   = 16,
    parameter int   SYNC = 2,
    parameter logic FILL = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sck,
    input  logic          i_ss,
    input  logic          i_mosi,
    input  logic [1:0]    i_mode,
    input  logic          i_msb,
    input  logic [DW-1:0] i_tx_data,
    input  logic          i_tx_valid,
    output logic          o_tx_ready,
    output logic [DW-1:0] o_rx_data,
    output logic          o_rx_valid,
    input  logic          i_rx_ready,
    output logic          o_miso,
    output logic          o_miso_oe,
    output logic          o_busy,
    output logic          o_overrun,
    output logic          o_underrun,
    input  logic          i_clr_flags
);

    localparam int            CW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC-1:0] sck_sync, ss_sync, mosi_sync;
    logic            sck_q, ss_q;
    logic            sck_s, ss_s, mosi_s;
    logic            sck_rise, sck_fall, ss_fall, ss_rise;

    logic            cpol_q, cpha_q, msb_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   rx_sh_q, rx_next;
    logic [DW-1:0]   tx_sh_q, hold_q;
    logic            tx_ready_q;
    logic [DW-1:0]   rx_data_q;
    logic            rx_valid_q, overrun_q, underrun_q;

    logic            in_frame, lead_edge, trail_edge;
    logic            sample_edge, shift_edge, word_done;
    logic            frame_start, load, tx_accept;
    logic            set_underrun, set_overrun;

    // SS chain resets to "asserted" so a select held low across reset never looks like a new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync  <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC-2:0], i_sck};
            ss_sync   <= {ss_sync[SYNC-2:0], i_ss};
            mosi_sync <= {mosi_sync[SYNC-2:0], i_mosi};
            sck_q     <= sck_sync[SYNC-1];
            ss_q      <= ss_sync[SYNC-1];
        end
    end

    assign sck_s    = sck_sync[SYNC-1];
    assign ss_s     = ss_sync[SYNC-1];
    assign mosi_s   = mosi_sync[SYNC-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign ss_fall  = ~ss_s & ss_q;
    assign ss_rise  = ss_s & ~ss_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        in_frame    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d     = ST_FRAME;
                    frame_start = 1'b1;
                end
            end
            ST_FRAME: begin
                if (ss_rise) state_d = ST_IDLE;
                else         in_frame = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = in_frame & (cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = in_frame & (cpha_q ? lead_edge : trail_edge);
    assign word_done   = sample_edge & (cnt_q == LAST);
    assign load        = frame_start | word_done;
    assign tx_accept   = i_tx_valid & tx_ready_q;

    assign rx_next = msb_q ? {rx_sh_q[DW-2:0], mosi_s} : {mosi_s, rx_sh_q[DW-1:1]};

    assign set_underrun = load & tx_ready_q & ~i_tx_valid;
    assign set_overrun  = word_done & rx_valid_q & ~i_rx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            msb_q   <= 1'b1;
            cnt_q   <= '0;
            rx_sh_q <= '0;
        end else if (frame_start) begin
            cpol_q  <= i_mode[1];
            cpha_q  <= i_mode[0];
            msb_q   <= i_msb;
            cnt_q   <= '0;
            rx_sh_q <= '0;
        end else if (ss_rise) begin
            cnt_q   <= '0;
            rx_sh_q <= '0;
        end else if (sample_edge) begin
            rx_sh_q <= rx_next;
            cnt_q   <= word_done ? '0 : cnt_q + CW'(1);
        end
    end

    // A zero count at a shift edge means a word was just loaded and its first bit is still unread.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_sh_q    <= {DW{FILL}};
            hold_q     <= '0;
            tx_ready_q <= 1'b1;
        end else if (load) begin
            if (!tx_ready_q) begin
                tx_sh_q    <= hold_q;
                tx_ready_q <= 1'b1;
            end else if (i_tx_valid) begin
                tx_sh_q <= i_tx_data;
            end else begin
                tx_sh_q <= {DW{FILL}};
            end
        end else begin
            if (shift_edge && (cnt_q != '0))
                tx_sh_q <= msb_q ? {tx_sh_q[DW-2:0], FILL} : {FILL, tx_sh_q[DW-1:1]};
            if (tx_accept) begin
                hold_q     <= i_tx_data;
                tx_ready_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (word_done) begin
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
        end else if (i_rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else if (i_clr_flags) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (set_overrun)  overrun_q  <= 1'b1;
            if (set_underrun) underrun_q <= 1'b1;
        end
    end

    assign o_miso     = msb_q ? tx_sh_q[DW-1] : tx_sh_q[0];
    assign o_miso_oe  = (state_q == ST_FRAME);
    assign o_busy     = (state_q == ST_FRAME);
    assign o_tx_ready = tx_ready_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_overrun  = overrun_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen: a behavioural SPI master drives frames and a
// word-level reference model predicts MISO words, received data and flag state.
module tb_spi_slave_gen;

    localparam int            DW    = 16;
    localparam int            HALF  = 8;
    localparam logic [DW-1:0] FILLW = '1;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_sck = 1'b0;
    logic          i_ss = 1'b1;
    logic          i_mosi = 1'b0;
    logic [1:0]    i_mode = 2'b00;
    logic          i_msb = 1'b1;
    logic [DW-1:0] i_tx_data = '0;
    logic          i_tx_valid = 1'b0;
    logic          o_tx_ready;
    logic [DW-1:0] o_rx_data;
    logic          o_rx_valid;
    logic          i_rx_ready = 1'b1;
    logic          o_miso;
    logic          o_miso_oe;
    logic          o_busy;
    logic          o_overrun;
    logic          o_underrun;
    logic          i_clr_flags = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] tx_w   [4];
    logic [DW-1:0] mosi_w [4];
    logic [DW-1:0] miso_w [4];

    logic rxv_q = 1'b0;
    int   rxv_rises = 0;

    spi_slave_gen #(.DW(DW), .SYNC(2), .FILL(1'b1)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sck      (i_sck),
        .i_ss       (i_ss),
        .i_mosi     (i_mosi),
        .i_mode     (i_mode),
        .i_msb      (i_msb),
        .i_tx_data  (i_tx_data),
        .i_tx_valid (i_tx_valid),
        .o_tx_ready (o_tx_ready),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .i_rx_ready (i_rx_ready),
        .o_miso     (o_miso),
        .o_miso_oe  (o_miso_oe),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_underrun (o_underrun),
        .i_clr_flags(i_clr_flags)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        rxv_q <= o_rx_valid;
        if (o_rx_valid && !rxv_q) rxv_rises <= rxv_rises + 1;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_data"},  o_rx_data,  0);
        check({tag, "_rx_valid"}, o_rx_valid, 0);
        check({tag, "_overrun"},  o_overrun,  0);
        check({tag, "_underrun"}, o_underrun, 0);
        check({tag, "_busy"},     o_busy,     0);
        check({tag, "_miso_oe"},  o_miso_oe,  0);
        check({tag, "_tx_ready"}, o_tx_ready, 1);
        check({tag, "_miso"},     o_miso,     1);
    endtask

    task automatic clr_flags();
        i_clr_flags = 1'b1;
        wait_clk(1);
        i_clr_flags = 1'b0;
    endtask

    task automatic push_tx(input logic [DW-1:0] w);
        int n = 0;
        while (!o_tx_ready && n < 4000) begin
            wait_clk(1);
            n++;
        end
        check("tx_ready_wait", o_tx_ready, 1);
        i_tx_data  = w;
        i_tx_valid = 1'b1;
        wait_clk(1);
        i_tx_valid = 1'b0;
    endtask

    // Bit i of the serial stream belongs to word i/DW at a position set by the bit order.
    function automatic int bit_pos(input int i, input logic msb);
        return msb ? (DW - 1 - (i % DW)) : (i % DW);
    endfunction

    function automatic logic mosi_bit(input int i, input logic msb);
        logic [DW-1:0] w;
        w = mosi_w[i / DW];
        return w[bit_pos(i, msb)];
    endfunction

    task automatic spi_xfer(input logic [1:0] mode, input logic msb, input int nbits);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        for (int k = 0; k < 4; k++) miso_w[k] = '0;
        i_mode = mode;
        i_msb  = msb;
        i_sck  = cpol;
        wait_clk(HALF);
        i_ss = 1'b0;
        if (!cpha) i_mosi = mosi_bit(0, msb);
        wait_clk(HALF);
        check("busy_in_frame", {o_busy, o_miso_oe}, 2'b11);
        i_mode = ~mode;
        i_msb  = ~msb;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) miso_w[i / DW][bit_pos(i, msb)] = o_miso;
            i_sck = ~cpol;
            if (cpha) i_mosi = mosi_bit(i, msb);
            wait_clk(HALF);
            if (cpha) miso_w[i / DW][bit_pos(i, msb)] = o_miso;
            i_sck = cpol;
            if (!cpha && (i + 1 < nbits)) i_mosi = mosi_bit(i + 1, msb);
            wait_clk(HALF);
        end
        i_ss   = 1'b1;
        i_mode = mode;
        i_msb  = msb;
        wait_clk(HALF);
    endtask

    // Model: a frame has one load at SS fall plus one per completed word; load k takes
    // TX word k when the bench provides one, otherwise an all-FILL word and sets underrun.
    task automatic run_frame(input string tag, input logic [1:0] mode, input logic msb,
                             input int nbits, input int ntx, input logic rx_rdy);
        int nw, loads, base;
        nw    = nbits / DW;
        loads = nw + 1;
        i_rx_ready = rx_rdy;
        clr_flags();
        if (ntx >= 1) push_tx(tx_w[0]);
        base = rxv_rises;
        fork
            spi_xfer(mode, msb, nbits);
            begin
                for (int k = 1; k < ntx; k++) push_tx(tx_w[k]);
            end
        join
        wait_clk(4);
        for (int k = 0; k < nw; k++)
            check({tag, "_miso_word"}, miso_w[k], (k < ntx) ? tx_w[k] : FILLW);
        if (nw > 0) check({tag, "_rx_data"}, o_rx_data, mosi_w[nw - 1]);
        if (rx_rdy) check({tag, "_rx_pulses"}, rxv_rises - base, nw);
        check({tag, "_underrun"}, o_underrun, (ntx < loads) ? 1 : 0);
        check({tag, "_overrun"},  o_overrun,  (!rx_rdy && nw >= 2) ? 1 : 0);
        check({tag, "_busy_end"}, o_busy, 0);
    endtask

    initial begin
        wait_clk(3);
        check_reset_vals("reset");
        i_rst_n = 1'b1;
        wait_clk(6);

        tx_w[0] = 16'hA55A; mosi_w[0] = 16'h1234;
        run_frame("m0_msb", 2'b00, 1'b1, 16, 1, 1'b1);

        for (int m = 1; m < 4; m++) begin
            tx_w[0] = 16'h00FF; mosi_w[0] = 16'hF00F;
            run_frame($sformatf("m%0d_lsb", m), 2'(m), 1'b0, 16, 1, 1'b1);
        end

        tx_w[0] = 16'h3C3C; mosi_w[0] = 16'h1111; mosi_w[1] = 16'h2222;
        run_frame("underrun", 2'b00, 1'b1, 32, 1, 1'b1);

        tx_w[0] = 16'h0F0F; tx_w[1] = 16'h7E81; tx_w[2] = 16'h5A5A;
        mosi_w[0] = 16'hCAFE; mosi_w[1] = 16'hD00D;
        run_frame("overrun", 2'b01, 1'b1, 32, 3, 1'b0);
        check("overrun_valid_held", o_rx_valid, 1);
        clr_flags();
        check("overrun_cleared", o_overrun, 0);
        i_rx_ready = 1'b1;
        wait_clk(2);
        check("rx_valid_consumed", o_rx_valid, 0);

        tx_w[0] = 16'h9999; mosi_w[0] = 16'h7F7F;
        run_frame("partial", 2'b00, 1'b1, 7, 1, 1'b1);
        tx_w[0] = 16'h4321; mosi_w[0] = 16'hBEEF;
        run_frame("after_partial", 2'b00, 1'b1, 16, 1, 1'b1);

        tx_w[0] = 16'h1357; mosi_w[0] = 16'h2468;
        push_tx(tx_w[0]);
        fork
            spi_xfer(2'b00, 1'b1, 16);
            begin
                wait_clk(100);
                i_rst_n = 1'b0;
                wait_clk(2);
                check_reset_vals("rst_mid");
                i_rst_n = 1'b1;
            end
        join
        wait_clk(4);
        check("rst_abort_no_rx", o_rx_valid, 0);
        check("rst_abort_idle", o_busy, 0);
        tx_w[0] = 16'h8421; mosi_w[0] = 16'h6B6B;
        run_frame("after_rst", 2'b00, 1'b1, 16, 1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int nw, ntx;
            logic [1:0] mode;
            logic msb;
            nw   = $urandom_range(1, 2);
            ntx  = $urandom_range(0, nw + 1);
            mode = 2'($urandom_range(0, 3));
            msb  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                tx_w[k]   = DW'($urandom);
                mosi_w[k] = DW'($urandom);
            end
            run_frame($sformatf("rand%0d", r), mode, msb, nw * DW, ntx, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
